// File: rtl/multi_cycle_controller.sv
// Main control FSM for the multi-cycle RV32I core (fetch/decode/execute/memory/writeback).
// Optional feature: define MC_ILLEGAL_TRAP_EN to trap unknown opcodes in a sticky TRAP state.
module multi_cycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic       illegal,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;

    logic   pc_update_s, branch_s, funct_op_s;
    logic   ir_write_s, mem_write_s, reg_write_s;

    // Next-state selection and the sticky illegal-opcode flag
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
                else           state_d = S_FETCH;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
`else
                        state_d   = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW)      state_d = S_MEMREAD;
                else if (op == OP_SW) state_d = S_MEMWRITE;
                else                  state_d = S_FETCH;
            end
            S_MEMREAD: begin
                if (mem_ready) state_d = S_MEMWB;
                else           state_d = S_MEMREAD;
            end
            S_MEMWRITE: begin
                if (mem_ready) state_d = S_FETCH;
                else           state_d = S_MEMWRITE;
            end
            S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BEQ:       state_d = S_FETCH;
            S_TRAP:                        state_d = S_TRAP;
            default:                       state_d = S_FETCH;
        endcase
`ifndef MC_ILLEGAL_TRAP_EN
        illegal_d = 1'b0;
`endif
    end

    // State and illegal-flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Per-state datapath controls; mem_ready and zero are the only Mealy inputs
    always_comb begin
        pc_update_s = 1'b0;
        branch_s    = 1'b0;
        funct_op_s  = 1'b0;
        ir_write_s  = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        case (state_q)
            S_FETCH: begin
                alu_src_b   = 2'b10;
                result_src  = 2'b10;
                ir_write_s  = mem_ready;
                pc_update_s = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_s = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a  = 2'b10;
                funct_op_s = 1'b1;
            end
            S_EXECUTEI: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                funct_op_s = 1'b1;
            end
            S_ALUWB:    reg_write_s = 1'b1;
            S_BEQ: begin
                alu_src_a = 2'b10;
                branch_s  = 1'b1;
            end
            S_JAL: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b10;
                pc_update_s = 1'b1;
            end
            default: pc_update_s = 1'b0;
        endcase
    end

    // ALU operation and immediate format decode
    always_comb begin
        alu_control = ALU_ADD;
        if (funct_op_s) begin
            case (funct3)
                3'b000:  alu_control = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
                3'b010:  alu_control = ALU_SLT;
                3'b110:  alu_control = ALU_OR;
                3'b111:  alu_control = ALU_AND;
                default: alu_control = ALU_ADD;
            endcase
        end else if (branch_s) begin
            alu_control = ALU_SUB;
        end else begin
            alu_control = ALU_ADD;
        end
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    // Write enables are dropped for as long as reset is held
    assign pc_write  = ~rst & (pc_update_s | (branch_s & zero));
    assign ir_write  = ~rst & ir_write_s;
    assign mem_write = ~rst & mem_write_s;
    assign reg_write = ~rst & reg_write_s;
    assign illegal   = illegal_q;
    assign state     = state_q;
endmodule

// File: doc/multi_cycle_controller.md
# multi_cycle_controller

Main control FSM for the multi-cycle RV32I core: sequences a shared-ALU, unified-memory datapath through fetch, decode, execute, memory and writeback. It sits beside the datapath at the core top and drives every multiplexer select and write enable from the latched opcode and the ALU zero flag. It stretches memory states until the memory's `mem_ready` handshake arrives.

## Interface
- No parameters.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `op`  in  7  opcode of the latched instruction register.
- `funct3`  in  3  instr[14:12].
- `funct7b5`  in  1  instr[30].
- `zero`  in  1  ALU zero flag, combinational from the current cycle.
- `mem_ready`  in  1  memory completed the current access this cycle.
- `pc_write`  out  1  PC register enable.
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_write`  out  1  memory write strobe.
- `ir_write`  out  1  instruction/OldPC register enable.
- `result_src`  out  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `alu_src_a`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1.
- `alu_src_b`  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- `alu_control`  out  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- `imm_src`  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- `reg_write`  out  1  register file write enable.
- `illegal`  out  1  sticky illegal-opcode flag (see Configuration).
- `state`  out  4  current state encoding, for debug and verification.

## Operation
- State encodings:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4.
  - MEMWRITE = 5, EXECUTER = 6, ALUWB = 7, EXECUTEI = 8, JAL = 9, BEQ = 10, TRAP = 11.
- Outputs are decoded combinationally from `state`. The only Mealy terms are `mem_ready` and `zero`.
- `pc_write` = pc_update | (branch & zero).
- Per-state outputs. Any signal not listed is 0; any select not listed is 00.
  - FETCH: alu_src_b = 10, result_src = 10, ir_write = mem_ready, pc_update = mem_ready.
  - DECODE: alu_src_a = 01, alu_src_b = 01 (branch target into ALUOut).
  - MEMADR: alu_src_a = 10, alu_src_b = 01.
  - MEMREAD: adr_src = 1.
  - MEMWB: result_src = 01, reg_write = 1.
  - MEMWRITE: adr_src = 1, mem_write = 1.
  - EXECUTER: alu_src_a = 10, alu_src_b = 00, aluop = funct.
  - EXECUTEI: alu_src_a = 10, alu_src_b = 01, aluop = funct.
  - ALUWB: result_src = 00, reg_write = 1.
  - BEQ: alu_src_a = 10, alu_src_b = 00, aluop = sub, branch = 1.
  - JAL: alu_src_a = 01, alu_src_b = 10, pc_update = 1.
- ALU decode: aluop is add by default and sub in BEQ. For aluop = funct, decode on funct3:
  - 000: sub if (op[5] & funct7b5), else add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - anything else: add.
- `imm_src` is decoded from `op`: sw → 01, beq → 10, jal → 11, otherwise 00.
- Transitions:
  - FETCH → DECODE when mem_ready; otherwise stay.
  - DECODE dispatches on `op`:
    - 0000011 (lw) or 0100011 (sw) → MEMADR.
    - 0110011 → EXECUTER.
    - 0010011 → EXECUTEI.
    - 1100011 → BEQ.
    - 1101111 → JAL.
    - anything else → illegal handling.
  - MEMADR → MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD → MEMWB when mem_ready; otherwise stay.
  - MEMWRITE → FETCH when mem_ready; otherwise stay, holding mem_write = 1 and the address.
  - EXECUTER, EXECUTEI and JAL → ALUWB.
  - MEMWB, ALUWB and BEQ → FETCH.

## Timing
- Reset: state = FETCH and illegal = 0.
- While `rst` is high, all write enables (pc_write, ir_write, mem_write, reg_write) are forced to 0. The selects hold their FETCH values.
- Cycle counts with zero wait states:
  - lw: 5.
  - sw: 4.
  - R-type, I-type ALU and jal: 4.
  - beq: 3.
- Each low-`mem_ready` cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. The outputs stay stable during those wait cycles.
- `mem_ready` is ignored in every other state.
- Reset asserted mid-instruction returns the FSM to FETCH immediately and asynchronously. Any write strobe of the current cycle is dropped.
- beq not-taken: pc_write stays 0 in BEQ. Taken: pc_write = 1 for exactly one cycle.

## Configuration
- `MC_ILLEGAL_TRAP_EN` defined:
  - An unknown opcode in DECODE → TRAP.
  - TRAP sets `illegal` = 1, drives all enables to 0, and stays until `rst`.
- `MC_ILLEGAL_TRAP_EN` undefined:
  - An unknown opcode in DECODE → FETCH, executing as a 2-cycle NOP.
  - `illegal` is tied to 0 and TRAP is unreachable.

## Test plan
- Reset: rst = 1 with mem_ready = 1 → state = 0, all enables 0. Release rst → ir_write = 1 and pc_write = 1 on the first cycle.
- lw (op = 0000011), mem_ready held at 0 for 2 cycles in MEMREAD → state sequence 0,1,2,3,3,3,4,0 with reg_write = 1 only in state 4.
- sw (op = 0100011) → mem_write = 1 only in state 5 with adr_src = 1. Holding mem_ready = 0 for 1 cycle there keeps mem_write = 1 for 2 cycles.
- R-type sub (funct3 = 000, funct7b5 = 1) → alu_control = 001 in state 6. Same fields with op = 0010011 → alu_control = 000 in state 8.
- beq with zero = 1 → pc_write = 1 in state 10. With zero = 0 → pc_write = 0 and the FSM returns to 0.
- op = 1111111: with MC_ILLEGAL_TRAP_EN → state 11 and illegal = 1, persisting until rst. Without it → back to state 0 after DECODE, illegal = 0.
